// File: rtl/code_conv_scheduler.sv
// code_conv_scheduler
//   Round-robin scheduler in front of one shared 4-bit code converter
//   (BCD, Gray, Hamming(7,4) even parity). One requester is granted at a
//   time: its word and mode are captured, converted in one registered step,
//   and the tagged result is held until the consumer accepts it.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [N_REQ]    requester i has a word pending
//   req_data   in   [4*N_REQ]  word of requester i at [4i+3:4i]
//   req_mode   in   [2*N_REQ]  mode of i at [2i+1:2i]: 00 BCD, 01 Gray, 10 Hamming, 11 reserved
//   req_ready  out  [N_REQ]    one-hot, one-cycle accept pulse to the granted requester
//   rsp_valid  out  result available, held until rsp_ready
//   rsp_id     out  [ID_W]     requester that owns the result
//   rsp_code   out  [7]        converted code (0 on error)
//   rsp_err    out  word > 9 or reserved mode
//   rsp_ready  in   consumer accepts the result while rsp_valid=1
//   busy       out  high in every state except IDLE
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for any req_valid; grants round-robin winner
// CONV   | captured word is converted into the rsp_* registers
// RESP   | result presented; waits for rsp_ready, then moves pointer

module code_conv_scheduler #(
  parameter int N_REQ = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [4*N_REQ-1:0] req_data,
  input  logic [2*N_REQ-1:0] req_mode,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [6:0]         rsp_code,
  output logic               rsp_err,
  input  logic               rsp_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [3:0]        cap_data;
  logic [1:0]        cap_mode;
  logic [ID_W-1:0]   cap_id;

  logic              found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  logic [N_REQ-1:0]  grant_oh;
  logic [3:0]        sel_data;
  logic [1:0]        sel_mode;

  // Search starts one past the last served requester so every requester
  // gets a turn; the modulo handles wrap from N_REQ-1 back to 0.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
  end

  always_comb begin
    sel_data = '0;
    sel_mode = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_data = req_data[4*i +: 4];
        sel_mode = req_mode[2*i +: 2];
      end
    end
  end

  // Returns {err, code}; code is forced to zero whenever err is set.
  function automatic logic [7:0] convert(input logic [3:0] d, input logic [1:0] m);
    logic       err;
    logic [6:0] code;
    err = (d > 4'd9) || (m == 2'b11);
    case (m)
      2'b00:   code = {3'b000, d};
      2'b01:   code = {3'b000, d[3], d[3] ^ d[2], d[2] ^ d[1], d[1] ^ d[0]};
      2'b10:   code = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
                       d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
      default: code = 7'd0;
    endcase
    if (err) code = 7'd0;
    return {err, code};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= ID_W'(N_REQ - 1);
      cap_data  <= '0;
      cap_mode  <= '0;
      cap_id    <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_code  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            cap_data  <= sel_data;
            cap_mode  <= sel_mode;
            cap_id    <= grant_id;
            req_ready <= grant_oh;
            busy      <= 1'b1;
            state     <= S_CONV;
          end
        end
        S_CONV: begin
          req_ready             <= '0;
          {rsp_err, rsp_code}   <= convert(cap_data, cap_mode);
          rsp_id                <= cap_id;
          rsp_valid             <= 1'b1;
          state                 <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            // Result fields return to zero so the bus idles clean.
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_code  <= '0;
            rsp_err   <= 1'b0;
            ptr       <= cap_id;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_conv_scheduler.sv
module tb_code_conv_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [4*N-1:0] req_data;
  logic [2*N-1:0] req_mode;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [6:0]   rsp_code;
  logic         rsp_err;
  logic         rsp_ready;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = N - 1;

  code_conv_scheduler #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_code  (rsp_code),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] d;
    logic [1:0] m;
    logic [6:0] code;
    logic       err;
    int         hold;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference conversion: Hamming built from the textbook positional rule
  // (parity at position 2^j covers every position with bit j set).
  function automatic logic [7:0] model(input logic [3:0] d, input logic [1:0] m);
    logic [7:0] pos;
    logic       p;
    if (int'(d) > 9 || m == 2'b11) return 8'h80;
    case (m)
      2'b00: return {4'b0, d};
      2'b01: return {4'b0, d ^ (d >> 1)};
      default: begin
        pos = '0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int j = 0; j < 3; j++) begin
          p = 1'b0;
          for (int q = 1; q < 8; q++)
            if ((q & (1 << j)) != 0) p = p ^ pos[3'(q)];
          pos[3'(1 << j)] = p;
        end
        return {1'b0, pos[7:1]};
      end
    endcase
  endfunction

  function automatic int winner(input logic [N-1:0] mask, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (mask[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] d, input logic [1:0] m);
    req_valid[i] = 1'b1;
    req_data[4*i +: 4] = d;
    req_mode[2*i +: 2] = m;
  endtask

  task automatic check_zero_outs(input string name);
    check(name, {req_ready, rsp_valid, rsp_id, rsp_code, rsp_err, busy}, 32'd0);
  endtask

  // Called at a negedge with the scheduler in IDLE and inputs already set.
  // 'late' requesters assert after the grant and must not disturb it.
  task automatic txn(input int id, input logic [7:0] exp, input int hold, input logic [N-1:0] late);
    tick;
    check("grant", req_ready, 32'(1 << id));
    check("busy_after_grant", busy, 1);
    check("rsp_before_conv", rsp_valid, 0);
    req_valid[id] = 1'b0;
    req_valid = req_valid | late;
    if (hold == 0) rsp_ready = 1'b1;
    tick;
    check("ready_one_cycle", req_ready, 0);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, 32'(id));
    check("rsp_code", rsp_code, exp[6:0]);
    check("rsp_err", rsp_err, exp[7]);
    for (int h = 0; h < hold; h++) begin
      tick;
      check("hold_stable", {rsp_valid, busy, req_ready, rsp_id, rsp_err, rsp_code},
            {1'b1, 1'b1, 4'b0, 2'(id), exp[7], exp[6:0]});
    end
    rsp_ready = 1'b1;
    tick;
    check("accept", {rsp_valid, busy, req_ready}, 0);
    rsp_ready = 1'b0;
    m_ptr = id;
  endtask

  initial begin
    logic [7:0] exp;
    int w;

    tbl[0] = '{2, 4'd3,  2'b01, 7'b0000010, 1'b0, 0};
    tbl[1] = '{1, 4'd5,  2'b10, 7'b0101101, 1'b0, 2};
    tbl[2] = '{3, 4'd9,  2'b00, 7'b0001001, 1'b0, 0};
    tbl[3] = '{0, 4'd12, 2'b00, 7'b0000000, 1'b1, 1};
    tbl[4] = '{2, 4'd5,  2'b11, 7'b0000000, 1'b1, 0};
    tbl[5] = '{1, 4'd10, 2'b01, 7'b0000000, 1'b1, 0};
    tbl[6] = '{0, 4'd9,  2'b10, 7'b1001100, 1'b0, 3};
    tbl[7] = '{3, 4'd15, 2'b01, 7'b0000000, 1'b1, 0};
    tbl[8] = '{0, 4'd0,  2'b10, 7'b0000000, 1'b0, 1};

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_mode = '0;
    rsp_ready = 1'b0;
    tick;
    tick;
    check_zero_outs("reset_idle");
    rst = 1'b0;
    tick;
    check_zero_outs("idle_after_reset");

    // rsp_ready with nothing presented is ignored
    rsp_ready = 1'b1;
    tick;
    check_zero_outs("idle_rsp_ready_ignored");
    rsp_ready = 1'b0;

    // reset while in CONV: nothing emitted for the discarded transaction
    set_req(1, 4'd4, 2'b00);
    tick;
    check("grant_before_rst", req_ready, 32'b0010);
    rst = 1'b1;
    #1;
    check_zero_outs("reset_in_conv");
    req_valid = '0;
    tick;
    rst = 1'b0;
    tick;
    check_zero_outs("no_rsp_after_conv_rst");
    m_ptr = N - 1;

    // table-driven single-requester vectors
    foreach (tbl[i]) begin
      set_req(tbl[i].id, tbl[i].d, tbl[i].m);
      txn(tbl[i].id, {tbl[i].err, tbl[i].code}, tbl[i].hold, '0);
    end

    // reset while in RESP holding a result for id 2
    set_req(2, 4'd3, 2'b01);
    tick;
    check("grant_id2", req_ready, 32'b0100);
    req_valid[2] = 1'b0;
    tick;
    check("resp_id2", {rsp_valid, rsp_id}, {1'b1, 2'd2});
    rst = 1'b1;
    #1;
    check_zero_outs("reset_in_resp");
    tick;
    rst = 1'b0;
    m_ptr = N - 1;
    tick;
    check_zero_outs("idle_after_resp_rst");

    // all four requesting continuously: order 0,1,2,3,0, long hold on one
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 5), 2'(i));
    for (int k = 0; k < 5; k++) begin
      w = winner(req_valid, m_ptr);
      check("rr_order", w, k % N);
      exp = model(req_data[4*w +: 4], req_mode[2*w +: 2]);
      txn(w, exp, (k == 2) ? 5 : 0, '0);
      set_req(w, 4'(w + 5), 2'(w));
    end
    req_valid = '0;
    tick;
    check_zero_outs("idle_after_rr");

    // randomized traffic against the reference model
    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 4'($urandom), 2'($urandom));
        else if (req_valid[i] && $urandom_range(0, 7) == 0)
          req_valid[i] = 1'b0;
      end
      if (req_valid == '0) begin
        tick;
        check_zero_outs("rand_idle");
      end else begin
        w = winner(req_valid, m_ptr);
        exp = model(req_data[4*w +: 4], req_mode[2*w +: 2]);
        txn(w, exp, $urandom_range(0, 3), 4'($urandom) & ~req_valid);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
